// File: rtl/gauss_blur3x3.sv
// Streaming 3x3 Gaussian smoother (1 2 1 / 2 4 2 / 1 2 1, rounded >>4); border pixels pass through raw.
// Optional sticky input-address checker with `err` port: define ADDR_CHECK_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FILL   | fewer than IMG_W+1 pixels accepted, no output yet
// S_STREAM | each accepted input emits output n-(IMG_W+1)
// S_FLUSH  | all inputs taken; emit last IMG_W+1 (border) outputs, 1/cycle
// S_DONE   | image complete, done=1, inputs ignored until rst
module gauss_blur3x3 #(
    parameter int IMG_W  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_data,
    output logic              done
`ifdef ADDR_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int LOG_W = $clog2(IMG_W);
    localparam int ROW_W = ADDR_W - LOG_W;

    localparam logic [ADDR_W:0]   CNT_FILL_LAST  = (ADDR_W+1)'(IMG_W);
    localparam logic [ADDR_W:0]   CNT_IN_LAST    = (ADDR_W+1)'((1 << ADDR_W) - 1);
    localparam logic [ADDR_W:0]   CNT_FLUSH_LAST = (ADDR_W+1)'((1 << ADDR_W) + IMG_W);
    localparam logic [ADDR_W:0]   CNT_ONE        = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] K_OFFSET       = ADDR_W'(IMG_W + 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic              adv;
    logic              emit;

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              done_q, done_d;

    logic [LOG_W-1:0]  ptr;
    logic [7:0]        lb1_mem [IMG_W];
    logic [7:0]        lb2_mem [IMG_W];
    logic [7:0]        lb1_rd;
    logic [7:0]        lb2_rd;
    logic [7:0]        new_bot;

    // Window columns: col0 = two samples back, col1 = one sample back; index 0 top, 2 bottom
    logic [7:0]        col0_q [3];
    logic [7:0]        col1_q [3];

    logic [ADDR_W-1:0] k;
    logic [ROW_W-1:0]  k_row;
    logic [LOG_W-1:0]  k_col;
    logic              border;
    logic [11:0]       sum;
    logic [7:0]        blur;
    logic [7:0]        pix_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        adv     = 1'b0;
        emit    = 1'b0;
        case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    adv = 1'b1;
                    if (n_q == CNT_FILL_LAST) state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (in_valid) begin
                    adv  = 1'b1;
                    emit = 1'b1;
                    if (n_q == CNT_IN_LAST) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                adv  = 1'b1;
                emit = 1'b1;
                if (n_q == CNT_FLUSH_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: state_d = S_FILL;
        endcase
        if (adv) n_d = n_q + CNT_ONE;
    end

    // Flush keeps the history shifting with dummy samples; only border (raw) outputs remain then
    assign new_bot = (state_q == S_FLUSH) ? 8'd0 : in_data;
    assign ptr     = n_q[LOG_W-1:0];
    assign lb1_rd  = lb1_mem[ptr];
    assign lb2_rd  = lb2_mem[ptr];

    always_ff @(posedge clk) begin
        if (adv) begin
            lb1_mem[ptr] <= new_bot;
            lb2_mem[ptr] <= lb1_rd;
            for (int i = 0; i < 3; i++) begin
                col0_q[i] <= col1_q[i];
            end
            col1_q[0] <= lb2_rd;
            col1_q[1] <= lb1_rd;
            col1_q[2] <= new_bot;
        end
    end

    assign k      = n_q[ADDR_W-1:0] - K_OFFSET;
    assign k_row  = k[ADDR_W-1:LOG_W];
    assign k_col  = k[LOG_W-1:0];
    assign border = (k_row == '0) || (k_row == '1) || (k_col == '0) || (k_col == '1);

    assign sum = 12'(col0_q[0])         + (12'(col1_q[0]) << 1) + 12'(lb2_rd)
               + (12'(col0_q[1]) << 1)  + (12'(col1_q[1]) << 2) + (12'(lb1_rd) << 1)
               + 12'(col0_q[2])         + (12'(col1_q[2]) << 1) + 12'(new_bot);

    assign blur    = 8'((sum + 12'd8) >> 4);
    assign pix_out = border ? col1_q[1] : blur;

    always_comb begin
        out_valid_d = emit;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        done_d      = (state_q == S_DONE);
        if (emit) begin
            out_addr_d = k;
            out_data_d = pix_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

`ifdef ADDR_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (adv && (state_q != S_FLUSH) && (in_addr != n_q[ADDR_W-1:0])) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_in_addr;
    assign unused_in_addr = ^in_addr;
`endif

endmodule

// File: tb/tb_gauss_blur3x3.sv
// Randomized self-checking bench for gauss_blur3x3 against a 2-D reference image model.
// Build with ADDR_CHECK_EN defined to exercise the address-mismatch flag.
module tb_gauss_blur3x3;

    localparam int IMG_W  = 128;
    localparam int ADDR_W = 14;
    localparam int N      = 1 << ADDR_W;
    localparam int H      = N / IMG_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [ADDR_W-1:0] in_addr = '0;
    logic [7:0]        in_data = '0;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic [7:0]        out_data;
    logic              done;
`ifdef ADDR_CHECK_EN
    logic              err;
`endif

    gauss_blur3x3 #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .done      (done)
`ifdef ADDR_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int img     [N];
    int exp_img [N];
    int got_img [N];
    int exp_idx   = 0;
    int last_addr = 0;
    int last_data = 0;
    bit in_reset    = 1'b1;
    bit inputs_done = 1'b0;
    bit inv_at_edge = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_pixel(input int r, input int c);
        int s;
        if (r == 0 || r == H-1 || c == 0 || c == IMG_W-1) return img[r*IMG_W + c];
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * img[(r+dr)*IMG_W + (c+dc)];
        return (s + 8) / 16;
    endfunction

    task automatic build_expected();
        for (int i = 0; i < N; i++) exp_img[i] = ref_pixel(i / IMG_W, i % IMG_W);
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_done", done, 0);
`ifdef ADDR_CHECK_EN
        check("rst_err", err, 0);
`endif
        exp_idx     = 0;
        last_addr   = 0;
        last_data   = 0;
        inputs_done = 1'b0;
        in_reset    = 1'b0;
    endtask

    task automatic feed(input bit gaps, input int count, input int bad_idx);
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 99) < 30) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    in_addr  = ADDR_W'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_addr  = (i == bad_idx) ? ADDR_W'(i - 1) : ADDR_W'(i);
            in_data  = 8'(img[i]);
            @(posedge clk);
            #1;
`ifdef ADDR_CHECK_EN
            if (bad_idx >= 0 && i == bad_idx - 1) check("err_before", err, 0);
            if (bad_idx >= 0 && i == bad_idx) check("err_set", err, 1);
`endif
        end
        in_valid = 1'b0;
        if (count == N) inputs_done = 1'b1;
    endtask

    task automatic finish_image(input bit junk, input bit check_lat);
        int cnt;
        cnt = 0;
        while (!done && cnt < 400) begin
            if (junk) begin
                in_valid = 1'($urandom);
                in_data  = 8'($urandom);
                in_addr  = ADDR_W'($urandom);
            end
            @(posedge clk);
            #1;
            cnt++;
        end
        check("done_rise", done, 1);
        if (check_lat) check("done_latency", cnt, IMG_W + 2);
        repeat (4) begin
            in_valid = junk ? 1'b1 : 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("done_held", done, 1);
        check("out_total", exp_idx, N);
    endtask

    task automatic mon_step();
        if (!inputs_done && !inv_at_edge) check("idle_no_write", out_valid, 0);
        if (done) check("done_no_write", out_valid, 0);
        if (out_valid) begin
            check("out_addr", out_addr, exp_idx);
            if (exp_idx < N) check("out_data", out_data, exp_img[exp_idx]);
            else check("out_extra", exp_idx, N - 1);
            got_img[out_addr] = out_data;
            exp_idx++;
            last_addr = out_addr;
            last_data = out_data;
        end else begin
            check("hold_addr", out_addr, last_addr);
            check("hold_data", out_data, last_data);
        end
    endtask

    initial begin
        int pr[13];
        int pc[13];
        int pv[13];
        pr = '{10,  9, 10, 11, 10,  9, 11, 5, 4, 6,   0, 1, 20};
        pc = '{10, 10,  9, 10, 11,  9, 11, 5, 5, 6,   0, 1, 20};
        pv = '{40, 20, 20, 20, 20, 10, 10, 2, 1, 1, 255, 16,  0};

        fork
            forever begin
                @(posedge clk);
                inv_at_edge = in_valid;
            end
            forever begin
                @(negedge clk);
                if (!in_reset) mon_step();
            end
        join_none

        // Constant image, continuous stream
        do_reset();
        for (int i = 0; i < N; i++) img[i] = 100;
        build_expected();
        feed(1'b0, N, -1);
        finish_image(1'b0, 1'b1);

        // Impulses: rounding, corner border, interior kernel shape
        do_reset();
        for (int i = 0; i < N; i++) img[i] = 0;
        img[10*IMG_W + 10] = 160;
        img[5*IMG_W + 5]   = 8;
        img[0]             = 255;
        build_expected();
        feed(1'b0, N, -1);
        finish_image(1'b0, 1'b1);
        for (int j = 0; j < 13; j++) check("impulse_px", got_img[pr[j]*IMG_W + pc[j]], pv[j]);

        // Partial random image, then reset mid-stream
        do_reset();
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
        build_expected();
        feed(1'b0, 3000, -1);

        // Fresh random image with idle gaps and one wrong address
        do_reset();
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
        build_expected();
        feed(1'b1, N, 500);
        finish_image(1'b1, 1'b0);
`ifdef ADDR_CHECK_EN
        check("err_held", err, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gauss_blur3x3.md
# gauss_blur3x3

Streaming 3x3 Gaussian smoothing stage placed directly downstream of the grayscale conversion stage. It consumes the 8-bit grayscale pixel stream (valid/addr/data, raster order, one pixel per cycle maximum) for a 128x128 image. It emits the smoothed image as a raster-ordered write stream (valid/addr/data) toward the result memory, and asserts `done` after the last pixel is written.

## Interface
- `IMG_W`, 128: image width in pixels; power of two.
- `ADDR_W`, 14: pixel address width; image height = 2^ADDR_W / IMG_W.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  input pixel present this cycle.
- `in_addr`  in  ADDR_W  input pixel address; must equal the count of pixels accepted so far.
- `in_data`  in  8  grayscale input pixel.
- `out_valid`  out  1  output pixel write strobe.
- `out_addr`  out  ADDR_W  output pixel address.
- `out_data`  out  8  smoothed pixel.
- `done`  out  1  all 2^ADDR_W outputs written; stays high until `rst`.
- `err`  out  1  sticky address-mismatch flag; exists only with `ADDR_CHECK_EN`.

## Operation
- Internal input counter `n` (ADDR_W+1 bits) increments on each accepted `in_valid`. The block stores the last 2*IMG_W+3 input samples using two IMG_W-deep line buffers plus a 3x3 register window.
- Kernel weights: 1 2 1 / 2 4 2 / 1 2 1. Sum is 12 bits, max 4080. `out_data` = (sum + 8) >> 4. The result never exceeds 255, so no saturation logic is needed.
- Border pixels pass through unfiltered: row 0, last row, col 0, col IMG_W-1 output the raw input value.
- Output pixel k is produced when input pixel k+IMG_W+1 is accepted.
- States:
  - FILL: n < IMG_W+1. No output.
  - STREAM: each accepted input emits output k = n-(IMG_W+1).
  - FLUSH: entered the cycle after input 2^ADDR_W-1 is accepted. It emits the remaining IMG_W+1 outputs, one per cycle, independent of `in_valid`. All of these are border pixels and therefore raw values.
  - DONE: `done`=1. `out_valid`=0. Inputs are ignored until `rst`.
- Gaps in `in_valid` stall the pipeline only; no output is emitted on an idle input cycle during FILL/STREAM.
- `in_valid` during FLUSH or DONE is ignored.
- Reset mid-operation clears the counter, state, and outputs. Line-buffer contents need not be cleared.

## Timing
- Reset values: `out_valid`=0, `out_addr`=0, `out_data`=0, `done`=0, `err`=0.
- All outputs are registered. `out_valid` rises one cycle after the accepting edge of input k+IMG_W+1.
- When `out_valid`=0, `out_data` and `out_addr` hold their previous values.
- Total output count is exactly 2^ADDR_W, with addresses strictly 0,1,...,2^ADDR_W-1 and no repeats.
- With an unstalled input stream, the last output is written IMG_W+1 cycles after the last input is accepted. `done` rises on the cycle after that last `out_valid`.

## Configuration
- `ADDR_CHECK_EN` defined:
  - On every accepted input, `in_addr` is compared with `n[ADDR_W-1:0]`.
  - A mismatch sets `err` on the following cycle; `err` stays high until `rst`.
  - Data flow is unaffected by a mismatch.
- Undefined: the `err` port and comparator are absent, and `in_addr` is ignored.

## Test plan
- Constant image of 100, continuous `in_valid` -> all 16384 outputs = 100, addresses 0..16383 in order, `done` high 130 cycles after the last input.
- Impulse 160 at (10,10), else 0 -> out(10,10)=40; out(9,10)=out(10,9)=out(11,10)=out(10,11)=20; diagonal neighbours=10; all others 0.
- Impulse 8 at (5,5) -> center 2, edge-neighbours 1, corners 1 (rounding check); impulse 255 at (0,0) -> out(0,0)=255 and out(1,1)=16.
- Random image with random `in_valid` gaps (~30% idle) -> output sequence identical to the continuous run; no `out_valid` on idle input cycles before FLUSH.
- `ADDR_CHECK_EN` defined, `in_addr` = 499 on the 500th pixel instead of 500 -> `err`=1 the next cycle and held; image output still correct.
- `rst` asserted mid-stream (after pixel 3000), then a full fresh image -> exactly 16384 outputs starting at address 0, correct values, `done` only at the end.
